// File: rtl/fir_sched.sv
// Two-requester round-robin scheduler and sequencer for the 8-bit fir increment pipeline.
// Runs one job at a time: accept, load strobe, wait LAT cycles, capture, respond.
module fir_sched #(
    parameter int unsigned LAT = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid_i,
    input  logic [7:0] req0_seed_i,
    output logic       req0_ready_o,
    input  logic       req1_valid_i,
    input  logic [7:0] req1_seed_i,
    output logic       req1_ready_o,
    output logic       pe_o,
    output logic [7:0] seed_o,
    input  logic [7:0] dp_out_i,
    output logic       rsp_valid_o,
    input  logic       rsp_ready_i,
    output logic [7:0] rsp_data_o,
    output logic       rsp_id_o,
    output logic       busy_o,
    output logic [7:0] done_cnt_o
);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_t;

    localparam logic [7:0] LAT_M1 = 8'(LAT - 1);

    state_t     state_q, state_d;
    logic       prio_q;
    logic       id_q;
    logic [7:0] cnt_q;
    logic       grant0, grant1;
    logic       accept;

    // With both valid, prio_q picks the winner; otherwise the lone requester wins.
    assign grant0 = req0_valid_i & (~req1_valid_i | ~prio_q);
    assign grant1 = req1_valid_i & (~req0_valid_i |  prio_q);

    assign req0_ready_o = (state_q == IDLE) & grant0;
    assign req1_ready_o = (state_q == IDLE) & grant1;
    assign accept       = req0_ready_o | req1_ready_o;

    assign pe_o        = (state_q == LOAD);
    assign rsp_valid_o = (state_q == RESP);
    assign busy_o      = (state_q != IDLE);

    // NOTE: state_d gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = LOAD;
            LOAD: state_d = WAIT;
            WAIT: if (cnt_q == 8'd0) state_d = RESP;
            RESP: if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seed_o     <= 8'd0;
            id_q       <= 1'b0;
            cnt_q      <= 8'd0;
            rsp_data_o <= 8'd0;
            rsp_id_o   <= 1'b0;
            prio_q     <= 1'b0;
            done_cnt_o <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        seed_o <= grant0 ? req0_seed_i : req1_seed_i;
                        id_q   <= grant1;
                    end
                end
                LOAD: cnt_q <= LAT_M1;
                WAIT: begin
                    if (cnt_q == 8'd0) begin
                        rsp_data_o <= dp_out_i;
                        rsp_id_o   <= id_q;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                RESP: begin
                    // The requester just served loses priority for the next contention.
                    if (rsp_ready_i) begin
                        prio_q     <= ~rsp_id_o;
                        done_cnt_o <= done_cnt_o + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_sched.sv
// Bench for fir_sched: timestamp-based job model checked every cycle, directed scenarios
// with literal expectations, a LAT=1 instance, and a randomized run through done counter wrap.
module tb_fir_sched;

    localparam int LAT = 9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v0 = 1'b0, v1 = 1'b0, rsp_ready = 1'b0;
    logic [7:0] s0 = 8'd0, s1 = 8'd0;
    logic       ready0, ready1, pe, rsp_valid, rsp_id, busy;
    logic [7:0] seed, dp_out, rsp_data, done_cnt;

    logic       b_v0 = 1'b0, b_rsp_ready = 1'b1;
    logic [7:0] b_s0 = 8'd0;
    logic       b_ready0, b_ready1, b_pe, b_rsp_valid, b_rsp_id, b_busy;
    logic [7:0] b_seed, b_dp_out, b_rsp_data, b_done_cnt;

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fir_sched #(.LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid_i(v0), .req0_seed_i(s0), .req0_ready_o(ready0),
        .req1_valid_i(v1), .req1_seed_i(s1), .req1_ready_o(ready1),
        .pe_o(pe), .seed_o(seed), .dp_out_i(dp_out),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .rsp_id_o(rsp_id),
        .busy_o(busy), .done_cnt_o(done_cnt)
    );

    fir_sched #(.LAT(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0_valid_i(b_v0), .req0_seed_i(b_s0), .req0_ready_o(b_ready0),
        .req1_valid_i(1'b0), .req1_seed_i(8'd0), .req1_ready_o(b_ready1),
        .pe_o(b_pe), .seed_o(b_seed), .dp_out_i(b_dp_out),
        .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
        .rsp_data_o(b_rsp_data), .rsp_id_o(b_rsp_id),
        .busy_o(b_busy), .done_cnt_o(b_done_cnt)
    );

    // Datapath models: 0xAA except seed+7 in the LAT-th cycle after the load strobe cycle.
    int dcnt, b_dcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) dcnt <= 0;
        else if (pe) dcnt <= 1;
        else if (dcnt == LAT) dcnt <= 0;
        else if (dcnt != 0) dcnt <= dcnt + 1;
    end
    assign dp_out = (dcnt == LAT) ? seed + 8'd7 : 8'hAA;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) b_dcnt <= 0;
        else if (b_pe) b_dcnt <= 1;
        else if (b_dcnt == 1) b_dcnt <= 0;
    end
    assign b_dp_out = (b_dcnt == 1) ? b_seed + 8'd7 : 8'hAA;

    // Job model: a job is described by its accept cycle m_a; everything else follows by arithmetic.
    int         cyc, m_a, m_hs_total, acc0, acc1;
    logic       m_active, m_prio, m_idq, m_id;
    logic [7:0] m_seed, m_data, m_done;
    logic       e_g0, e_g1;

    assign e_g0 = !m_active && v0 && (!v1 || !m_prio);
    assign e_g1 = !m_active && v1 && (!v0 || m_prio);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc <= 0; m_a <= 0; m_hs_total <= 0; acc0 <= 0; acc1 <= 0;
            m_active <= 1'b0; m_prio <= 1'b0; m_idq <= 1'b0; m_id <= 1'b0;
            m_seed <= 8'd0; m_data <= 8'd0; m_done <= 8'd0;
        end else begin
            cyc <= cyc + 1;
            if (!m_active) begin
                if (e_g0 || e_g1) begin
                    m_active <= 1'b1;
                    m_a      <= cyc + 1;
                    m_seed   <= e_g0 ? s0 : s1;
                    m_idq    <= e_g1;
                    if (e_g0) acc0 <= acc0 + 1;
                    else acc1 <= acc1 + 1;
                end
            end else if (cyc == m_a + LAT) begin
                m_data <= m_seed + 8'd7;
                m_id   <= m_idq;
            end else if (cyc > m_a + LAT && rsp_ready) begin
                m_prio     <= !m_id;
                m_done     <= m_done + 8'd1;
                m_hs_total <= m_hs_total + 1;
                m_active   <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", busy, m_active);
            check("pe", pe, m_active && cyc == m_a);
            check("rsp_valid", rsp_valid, m_active && cyc > m_a + LAT);
            check("ready0", ready0, e_g0);
            check("ready1", ready1, e_g1);
            check("seed", seed, m_seed);
            check("rsp_data", rsp_data, m_data);
            check("rsp_id", rsp_id, m_id);
            check("done_cnt", done_cnt, m_done);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_rsp(input string name, output int edges);
        edges = 0;
        while (!rsp_valid && edges < 100) begin
            tick();
            edges++;
        end
        check(name, rsp_valid, 1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check(name, busy, 0);
    endtask

    initial begin
        int edges;
        int n;
        logic       ids [4];
        logic [7:0] dat [4];
        logic       exp_ids [4];
        logic [7:0] exp_dat [4];
        bit wrapped;
        int p0, p1;

        // Reset state
        #1;
        check("rst_pe", pe, 0);
        check("rst_seed", seed, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done_cnt, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        check("idle_ready0_novalid", ready0, 0);

        // Single job, LAT=9
        rsp_ready = 1'b1;
        v0 = 1'b1; s0 = 8'h10;
        #1;
        check("t1_ready0", ready0, 1);
        check("t1_ready1", ready1, 0);
        tick();
        v0 = 1'b0;
        check("t1_pe", pe, 1);
        check("t1_seed", seed, 8'h10);
        wait_rsp("t1_rsp", edges);
        check("t1_latency", edges, 10);
        check("t1_data", rsp_data, 8'h17);
        check("t1_id", rsp_id, 0);
        tick();
        check("t1_done", done_cnt, 1);
        check("t1_valid_low", rsp_valid, 0);

        // Contention from fresh priority
        do_reset();
        v0 = 1'b1; s0 = 8'h20; v1 = 1'b1; s1 = 8'h40;
        n = 0;
        for (int i = 0; i < 200 && n < 4; i++) begin
            tick();
            if (rsp_valid && rsp_ready) begin
                ids[n] = rsp_id;
                dat[n] = rsp_data;
                n++;
                if (n == 4) begin v0 = 1'b0; v1 = 1'b0; end
            end
        end
        check("t2_count", n, 4);
        exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_dat = '{8'h27, 8'h47, 8'h27, 8'h47};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_id%0d", i), ids[i], exp_ids[i]);
            check($sformatf("t2_data%0d", i), dat[i], exp_dat[i]);
        end
        wait_idle("t2_idle");

        // Back-pressure with req1 waiting
        v0 = 1'b1; s0 = 8'h33; v1 = 1'b1; s1 = 8'h55; rsp_ready = 1'b0;
        tick();
        v0 = 1'b0;
        wait_rsp("t3_rsp", edges);
        for (int i = 0; i < 5; i++) begin
            check("t3_valid", rsp_valid, 1);
            check("t3_data", rsp_data, 8'h3A);
            check("t3_id", rsp_id, 0);
            check("t3_ready0", ready0, 0);
            check("t3_ready1", ready1, 0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("t3_done", done_cnt, 5);
        check("t3_ready1_after", ready1, 1);
        tick();
        v1 = 1'b0;
        check("t3_pe", pe, 1);
        check("t3_seed", seed, 8'h55);
        wait_rsp("t3_rsp2", edges);
        check("t3_data2", rsp_data, 8'h5C);
        check("t3_id2", rsp_id, 1);
        wait_idle("t3_idle");

        // Reset during WAIT cycle 3
        v0 = 1'b1; s0 = 8'h61;
        tick();
        v0 = 1'b0;
        repeat (3) tick();
        check("t5_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        check("t5_pe", pe, 0);
        check("t5_seed", seed, 0);
        check("t5_valid", rsp_valid, 0);
        check("t5_data", rsp_data, 0);
        check("t5_id", rsp_id, 0);
        check("t5_busy", busy, 0);
        check("t5_done", done_cnt, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        v0 = 1'b1; s0 = 8'h61;
        tick();
        v0 = 1'b0;
        wait_rsp("t5_rsp", edges);
        check("t5_latency", edges, 10);
        check("t5_data2", rsp_data, 8'h68);
        check("t5_done_pre", done_cnt, 0);
        tick();
        check("t5_done_post", done_cnt, 1);

        // LAT=1 boundary on the second instance
        b_v0 = 1'b1; b_s0 = 8'hFE;
        tick();
        b_v0 = 1'b0;
        check("t4_pe", b_pe, 1);
        check("t4_seed", b_seed, 8'hFE);
        tick();
        check("t4_wait_valid", b_rsp_valid, 0);
        check("t4_wait_busy", b_busy, 1);
        tick();
        check("t4_valid", b_rsp_valid, 1);
        check("t4_data", b_rsp_data, 8'h05);
        check("t4_id", b_rsp_id, 0);
        tick();
        check("t4_done", b_done_cnt, 1);

        // Random traffic until the done counter wraps
        do_reset();
        wrapped = 1'b0;
        p0 = acc0; p1 = acc1;
        for (int i = 0; i < 20000 && m_hs_total < 260; i++) begin
            tick();
            if (acc0 != p0) begin p0 = acc0; v0 = 1'b0; end
            if (acc1 != p1) begin p1 = acc1; v1 = 1'b0; end
            if (!v0 && $urandom_range(0, 2) != 0) begin v0 = 1'b1; s0 = 8'($urandom); end
            if (!v1 && $urandom_range(0, 2) != 0) begin v1 = 1'b1; s1 = 8'($urandom); end
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (m_hs_total == 256 && !wrapped) begin
                check("t6_wrap", done_cnt, 0);
                wrapped = 1'b1;
            end
        end
        check("t6_wrap_reached", wrapped, 1);
        v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b1;
        wait_idle("t6_idle");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
